// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
//   MEM_COMMAND   - command encoding toward the memory model
//   I_ADDR_PACKET - valid + block tag (address bits above the 8-byte block offset)
//   WB_ENTRY      - one write-buffer slot: valid, block tag, block data
//   ARB_SEL       - which candidate the arbiter picked this cycle
//   pkt_to_addr   - block tag -> block-aligned byte address
package mem_arb_pkg;

   localparam int MEM_ARB_WB_DEPTH = 4;
   localparam int ADDR_W           = 32;
   localparam int BTAG_W           = 13;
   localparam int MEM_TAG_W        = 4;

   typedef logic [ADDR_W-1:0]    ADDR;
   typedef logic [63:0]          MEM_BLOCK;
   typedef logic [MEM_TAG_W-1:0] MEM_TAG;

   typedef enum logic [1:0] {
      MEM_NONE  = 2'd0,
      MEM_LOAD  = 2'd1,
      MEM_STORE = 2'd2
   } MEM_COMMAND;

   typedef struct packed {
      logic              valid;
      logic [BTAG_W-1:0] tag;
   } I_ADDR_PACKET;

   typedef struct packed {
      logic              valid;
      logic [BTAG_W-1:0] tag;
      MEM_BLOCK          data;
   } WB_ENTRY;

   typedef enum logic [1:0] {
      SEL_NONE  = 2'd0,
      SEL_STORE = 2'd1,
      SEL_DLOAD = 2'd2,
      SEL_ILOAD = 2'd3
   } ARB_SEL;

   function automatic ADDR pkt_to_addr(input logic [BTAG_W-1:0] tag);
      return {{(ADDR_W-BTAG_W-3){1'b0}}, tag, 3'b000};
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular write buffer for dcache dirty writebacks.
//   clock, reset      - rising edge, synchronous active-high reset
//   push_i            - write tag/data into the tail slot
//   push_tag_i/_data_i- writeback contents
//   pop_i             - retire the head slot
//   full_o, empty_o   - occupancy flags
//   count_o           - occupancy, clog2(DEPTH)+1 bits
//   head_o            - oldest entry
//   entries_o         - every slot, for address comparison by the owner
//   drop_o            - a push was refused this cycle (full and no pop)
module wb_fifo
   import mem_arb_pkg::*;
#(
   parameter  int DEPTH = MEM_ARB_WB_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  push_i,
   input  logic [BTAG_W-1:0]     push_tag_i,
   input  MEM_BLOCK              push_data_i,
   input  logic                  pop_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [CNT_W-1:0]      count_o,
   output WB_ENTRY               head_o,
   output WB_ENTRY [DEPTH-1:0]   entries_o,
   output logic                  drop_o
);

   logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]    count_q, count_d;
   WB_ENTRY [DEPTH-1:0] mem_q, mem_d;
   logic                do_pop, do_push;

   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign head_o    = mem_q[head_q];
   assign entries_o = mem_q;

   always_comb begin
      do_pop  = pop_i && !empty_o;
      // At full a simultaneous pop frees the slot the tail is about to reuse.
      do_push = push_i && (!full_o || do_pop);
      drop_o  = push_i && !do_push;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      mem_d   = mem_q;
      if (do_pop) begin
         mem_d[head_q].valid = 1'b0;
         head_d              = head_q + 1'b1;
      end
      if (do_push) begin
         mem_d[tail_q].valid = 1'b1;
         mem_d[tail_q].tag   = push_tag_i;
         mem_d[tail_q].data  = push_data_i;
         tail_d              = tail_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         mem_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: picks one memory command per cycle among buffered dcache
// writebacks, dcache reads and icache reads.
//   clock, reset                 - rising edge, synchronous active-high reset
//   icache_req_addr / _accepted  - icache read request and same-cycle accept
//   dcache_req_addr / _accepted  - dcache read request and same-cycle accept
//   dcache_write_valid/addr/data - unhandshaked writeback, absorbed by wb_fifo
//   proc2mem_command/addr/data   - command to memory (idle: NONE, 0, 0)
//   mem2proc_transaction_tag     - same-cycle memory reply, 0 = rejected
//   current_req_tag              - memory tag of an issued load, else 0
//   wb_full, wb_overflow         - buffer full; sticky dropped-writeback flag
// Build option MEM_ARB_RAW_CHECK_EN: reads go first, with dcache reads blocked
// on an address match against the buffer or the incoming writeback. Without
// it the buffer always drains first and no address comparators exist.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WB_DEPTH = MEM_ARB_WB_DEPTH
) (
   input  logic         clock,
   input  logic         reset,
   input  I_ADDR_PACKET icache_req_addr,
   output logic         icache_req_accepted,
   input  I_ADDR_PACKET dcache_req_addr,
   output logic         dcache_req_accepted,
   input  logic         dcache_write_valid,
   input  I_ADDR_PACKET dcache_write_addr,
   input  MEM_BLOCK     dcache_write_data,
   output MEM_TAG       current_req_tag,
   output MEM_COMMAND   proc2mem_command,
   output ADDR          proc2mem_addr,
   output MEM_BLOCK     proc2mem_data,
   input  MEM_TAG       mem2proc_transaction_tag,
   output logic         wb_full,
   output logic         wb_overflow
);

   localparam int CNT_W = $clog2(WB_DEPTH) + 1;

   logic                   wb_full_int, wb_empty, wb_drop, wb_pop, wb_push;
   logic [CNT_W-1:0]       wb_count;
   WB_ENTRY                wb_head;
   WB_ENTRY [WB_DEPTH-1:0] wb_entries;
   ARB_SEL                 sel;
   logic                   accept;
   logic                   wb_overflow_q, wb_overflow_d;
   logic                   unused_bits;

   wb_fifo #(.DEPTH(WB_DEPTH)) u_wb_fifo (
      .clock       (clock),
      .reset       (reset),
      .push_i      (wb_push),
      .push_tag_i  (dcache_write_addr.tag),
      .push_data_i (dcache_write_data),
      .pop_i       (wb_pop),
      .full_o      (wb_full_int),
      .empty_o     (wb_empty),
      .count_o     (wb_count),
      .head_o      (wb_head),
      .entries_o   (wb_entries),
      .drop_o      (wb_drop)
   );

`ifdef MEM_ARB_RAW_CHECK_EN
   logic raw_hit;

   // A dcache read must not overtake a pending store to its own block,
   // including one arriving this very cycle.
   always_comb begin
      raw_hit = dcache_write_valid && (dcache_write_addr.tag == dcache_req_addr.tag);
      for (int i = 0; i < WB_DEPTH; i++) begin
         if (wb_entries[i].valid && (wb_entries[i].tag == dcache_req_addr.tag))
            raw_hit = 1'b1;
      end
   end

   always_comb begin
      sel = SEL_NONE;
      if (!reset) begin
         if (wb_full_int)
            sel = SEL_STORE;
         else if (dcache_req_addr.valid && !raw_hit)
            sel = SEL_DLOAD;
         else if (dcache_req_addr.valid && !wb_empty)
            sel = SEL_STORE;      // blocked dcache read yields its slot to the head store
         else if (icache_req_addr.valid)
            sel = SEL_ILOAD;
         else if (!wb_empty)
            sel = SEL_STORE;
      end
   end

   assign unused_bits = ^{wb_count, wb_head.valid, dcache_write_addr.valid};
`else
   // Store-first: any buffered store to the read's block drains ahead of it.
   // A writeback arriving this cycle is not in the buffer yet, so a dcache
   // read is held off whenever one arrives.
   always_comb begin
      sel = SEL_NONE;
      if (!reset) begin
         if (!wb_empty)
            sel = SEL_STORE;
         else if (dcache_req_addr.valid && !dcache_write_valid)
            sel = SEL_DLOAD;
         else if (icache_req_addr.valid)
            sel = SEL_ILOAD;
      end
   end

   assign unused_bits = ^{wb_count, wb_head.valid, wb_entries, dcache_write_addr.valid};
`endif

   assign accept  = (mem2proc_transaction_tag != '0);
   assign wb_pop  = (sel == SEL_STORE) && accept;
   assign wb_push = dcache_write_valid && !reset;

   always_comb begin
      proc2mem_command = MEM_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      current_req_tag  = '0;
      case (sel)
         SEL_STORE: begin
            proc2mem_command = MEM_STORE;
            proc2mem_addr    = pkt_to_addr(wb_head.tag);
            proc2mem_data    = wb_head.data;
         end
         SEL_DLOAD: begin
            proc2mem_command = MEM_LOAD;
            proc2mem_addr    = pkt_to_addr(dcache_req_addr.tag);
            current_req_tag  = mem2proc_transaction_tag;
         end
         SEL_ILOAD: begin
            proc2mem_command = MEM_LOAD;
            proc2mem_addr    = pkt_to_addr(icache_req_addr.tag);
            current_req_tag  = mem2proc_transaction_tag;
         end
         default: ;
      endcase
   end

   assign dcache_req_accepted = (sel == SEL_DLOAD) && accept;
   assign icache_req_accepted = (sel == SEL_ILOAD) && accept;

   assign wb_overflow_d = wb_overflow_q || wb_drop;

   always_ff @(posedge clock) begin
      if (reset) wb_overflow_q <= 1'b0;
      else       wb_overflow_q <= wb_overflow_d;
   end

   assign wb_overflow = wb_overflow_q;
   assign wb_full     = wb_full_int;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed test-plan sequences followed by random traffic.
// Stimulus drives each cycle and pushes the reference model's expectation;
// a monitor pops and compares the DUT outputs in the same cycle.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int DEPTH = 4;

   logic         clock = 1'b0;
   logic         reset;
   I_ADDR_PACKET icache_req_addr, dcache_req_addr, dcache_write_addr;
   logic         icache_req_accepted, dcache_req_accepted;
   logic         dcache_write_valid;
   MEM_BLOCK     dcache_write_data;
   MEM_TAG       current_req_tag, mem2proc_transaction_tag;
   MEM_COMMAND   proc2mem_command;
   ADDR          proc2mem_addr;
   MEM_BLOCK     proc2mem_data;
   logic         wb_full, wb_overflow;

   mem_arbiter #(.WB_DEPTH(DEPTH)) dut (
      .clock                    (clock),
      .reset                    (reset),
      .icache_req_addr          (icache_req_addr),
      .icache_req_accepted      (icache_req_accepted),
      .dcache_req_addr          (dcache_req_addr),
      .dcache_req_accepted      (dcache_req_accepted),
      .dcache_write_valid       (dcache_write_valid),
      .dcache_write_addr        (dcache_write_addr),
      .dcache_write_data        (dcache_write_data),
      .current_req_tag          (current_req_tag),
      .proc2mem_command         (proc2mem_command),
      .proc2mem_addr            (proc2mem_addr),
      .proc2mem_data            (proc2mem_data),
      .mem2proc_transaction_tag (mem2proc_transaction_tag),
      .wb_full                  (wb_full),
      .wb_overflow              (wb_overflow)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [12:0] tag;
      logic [63:0] data;
   } wbe_t;

   typedef struct {
      logic [1:0]  cmd;
      logic [31:0] addr;
      logic [63:0] data;
      logic        iacc, dacc;
      logic [3:0]  rtag;
      logic        full, ovf, regs_known;
   } exp_t;

   wbe_t mq[$];
   exp_t exp_q[$];
   bit   movf  = 0;
   bit   known = 0;
   int   checks = 0, failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h @%0t", nm, act, req, $time);
      end
   endtask

   // One clock of stimulus plus the expected response from the reference model.
   task automatic cyc(input bit iv, input logic [12:0] it, input bit dv, input logic [12:0] dt,
                      input bit wv, input logic [12:0] wt, input logic [63:0] wd,
                      input logic [3:0] mt, input bit rst);
      exp_t e;
      int   pick;   // 0 none, 1 store, 2 dcache load, 3 icache load
      bit   have_st, hazard;
      logic [12:0] t;
      @(negedge clock);
      reset = rst;
      icache_req_addr = '{valid: iv, tag: it};
      dcache_req_addr = '{valid: dv, tag: dt};
      dcache_write_valid = wv;
      dcache_write_addr = '{valid: wv, tag: wt};
      dcache_write_data = wd;
      mem2proc_transaction_tag = mt;

      e.full = (mq.size() == DEPTH);
      e.ovf = movf;
      e.regs_known = known;
      pick = 0;
      hazard = 0;
      have_st = (mq.size() > 0);
      if (!rst) begin
`ifdef MEM_ARB_RAW_CHECK_EN
         if (wv && wt == dt) hazard = 1;
         foreach (mq[k]) if (mq[k].tag == dt) hazard = 1;
         if (mq.size() == DEPTH)   pick = 1;
         else if (dv && !hazard)   pick = 2;
         else if (dv && have_st)   pick = 1;
         else if (iv)              pick = 3;
         else if (have_st)         pick = 1;
`else
         if (have_st)              pick = 1;
         else if (dv && !wv)       pick = 2;
         else if (iv)              pick = 3;
`endif
      end
      e.cmd = 2'd0; e.addr = 0; e.data = 0; e.iacc = 0; e.dacc = 0; e.rtag = 0;
      if (pick == 1) begin
         e.cmd = 2'd2; t = mq[0].tag; e.addr = 32'(t) * 8; e.data = mq[0].data;
      end else if (pick == 2) begin
         e.cmd = 2'd1; e.addr = 32'(dt) * 8; e.rtag = mt; e.dacc = (mt != 0);
      end else if (pick == 3) begin
         e.cmd = 2'd1; e.addr = 32'(it) * 8; e.rtag = mt; e.iacc = (mt != 0);
      end
      exp_q.push_back(e);

      // State after this clock edge.
      if (rst) begin
         mq.delete();
         movf = 0;
         known = 1;
      end else begin
         if (pick == 1 && mt != 0) void'(mq.pop_front());
         if (wv) begin
            if (mq.size() < DEPTH) mq.push_back('{tag: wt, data: wd});
            else movf = 1;
         end
      end
   endtask

   task automatic idle(input logic [3:0] mt);
      cyc(0, 0, 0, 0, 0, 0, 0, mt, 0);
   endtask

   // Monitor: compares every cycle's outputs against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("command", 64'(proc2mem_command), 64'(e.cmd));
            chk("addr", 64'(proc2mem_addr), 64'(e.addr));
            chk("data", proc2mem_data, e.data);
            chk("icache_acc", 64'(icache_req_accepted), 64'(e.iacc));
            chk("dcache_acc", 64'(dcache_req_accepted), 64'(e.dacc));
            chk("req_tag", 64'(current_req_tag), 64'(e.rtag));
            if (e.regs_known) begin
               chk("wb_full", 64'(wb_full), 64'(e.full));
               chk("wb_overflow", 64'(wb_overflow), 64'(e.ovf));
            end
         end
      end
   end

   initial begin
      logic [12:0] a, b;
      reset = 1'b1;
      icache_req_addr = '0; dcache_req_addr = '0; dcache_write_addr = '0;
      dcache_write_valid = 0; dcache_write_data = '0; mem2proc_transaction_tag = '0;

      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(0);

      // isolated icache read, accepted then rejected/retried
      cyc(1, 13'h200, 0, 0, 0, 0, 0, 4'd3, 0);
      cyc(1, 13'h200, 0, 0, 0, 0, 0, 4'd0, 0);
      cyc(1, 13'h200, 0, 0, 0, 0, 0, 4'd5, 0);

      // simultaneous dcache/icache
      cyc(1, 13'h600, 1, 13'h400, 0, 0, 0, 4'd1, 0);
      cyc(1, 13'h600, 0, 0, 0, 0, 0, 4'd2, 0);

      // writeback drain
      cyc(0, 0, 0, 0, 1, 13'h800, 64'hDEADBEEF_CAFEF00D, 4'd6, 0);
      idle(4'd7);

      // read after write to the same block, then an unrelated read
      cyc(0, 0, 0, 0, 1, 13'hA00, 64'h1111_2222_3333_4444, 4'd2, 0);
      cyc(0, 0, 1, 13'hA00, 0, 0, 0, 4'd4, 0);
      cyc(0, 0, 1, 13'hA00, 0, 0, 0, 4'd4, 0);
      cyc(0, 0, 0, 0, 1, 13'hB00, 64'h5555, 4'd3, 0);
      cyc(0, 0, 1, 13'hC00, 0, 0, 0, 4'd3, 0);
      idle(4'd3); idle(4'd3);

      // overflow: DEPTH+1 writebacks while memory rejects, then drain
      for (int i = 0; i <= DEPTH; i++)
         cyc(0, 0, 0, 0, 1, 13'(13'h100 + i), 64'(64'hA0 + i), 4'd0, 0);
      for (int i = 0; i < DEPTH + 2; i++) idle(4'd9);

      // push and pop together at full
      for (int i = 0; i < DEPTH; i++)
         cyc(0, 0, 0, 0, 1, 13'(13'h140 + i), 64'(64'hB0 + i), 4'd0, 0);
      cyc(0, 0, 0, 0, 1, 13'h150, 64'hBF, 4'd3, 0);
      idle(4'd0);
      for (int i = 0; i < DEPTH + 1; i++) idle(4'd8);

      // reset with two entries pending
      cyc(0, 0, 0, 0, 1, 13'h160, 64'hC0, 4'd0, 0);
      cyc(0, 0, 0, 0, 1, 13'h161, 64'hC1, 4'd0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 4'd5, 1);
      idle(4'd5); idle(4'd5); idle(4'd5);

      // random traffic on a small address set so hazards occur often
      for (int n = 0; n < 3000; n++) begin
         a = 13'(13'h200 + $urandom_range(0, 5));
         b = 13'(13'h200 + $urandom_range(0, 5));
         cyc($urandom_range(0, 1), 13'(13'h300 + $urandom_range(0, 3)),
             $urandom_range(0, 1), a,
             ($urandom_range(0, 9) < 4), b, {$urandom, $urandom},
             ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
             ($urandom_range(0, 199) == 0));
      end

      repeat (3) @(negedge clock);
      #4;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory-side responder for the cache subsystems: accepts read requests from the icache and dcache, absorbs dcache dirty writebacks into a small write buffer, and issues at most one command per cycle to the memory model. The block returns the accepting transaction tag to the requesters, who record it in their MSHRs and later match it against the returning data tag. Writebacks arrive without a handshake, so the arbiter owns all buffering and ordering between stores and later loads to the same block.

## Interface
- `WB_DEPTH`, 4: write-buffer entries; must be a power of 2, ≥2.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `icache_req_addr` in I_ADDR_PACKET: icache read request; valid plus block address.
- `icache_req_accepted` out 1: icache request issued and accepted this cycle.
- `dcache_req_addr` in I_ADDR_PACKET: dcache read request (oldest miss).
- `dcache_req_accepted` out 1: dcache request issued and accepted this cycle.
- `dcache_write_valid` in 1: dirty writeback present this cycle; no handshake.
- `dcache_write_addr` in I_ADDR_PACKET: writeback block address.
- `dcache_write_data` in MEM_BLOCK: writeback data.
- `current_req_tag` out MEM_TAG: the memory's transaction tag, broadcast to both caches.
- `proc2mem_command` out MEM_COMMAND: MEM_NONE, MEM_LOAD or MEM_STORE.
- `proc2mem_addr` out ADDR: block-aligned address; bits [2:0] are 0.
- `proc2mem_data` out MEM_BLOCK: store data; 0 when not storing.
- `mem2proc_transaction_tag` in MEM_TAG: same-cycle response to the command; 0 means rejected.
- `wb_full` out 1: write-buffer occupancy equals WB_DEPTH.
- `wb_overflow` out 1: sticky; set when a writeback was dropped.

## Operation
- Write buffer: circular FIFO with head, tail and count (width clog2(WB_DEPTH)+1).
  - Push on `dcache_write_valid`.
  - Pop when the head store is issued and `mem2proc_transaction_tag` is nonzero.
- Arbitration: one candidate is chosen per cycle, then gated by acceptance (tag ≠ 0).
  - An accepted read asserts its `*_accepted` output.
  - A rejected command causes no state change; the same candidate is re-evaluated the next cycle.
- Priority without the configuration macro: buffered store, then dcache read, then icache read. Any non-empty buffer drains before any dcache or icache read issues.
- Address conversion: `proc2mem_addr` = {zeros, tag, 3'b0} from the packet.
- Idle: when no candidate exists, drive command MEM_NONE, addr 0, data 0.
- `current_req_tag` = `mem2proc_transaction_tag` when a load is issued, otherwise 0. Store tags are never reported.
- Overflow:
  - A push while count == WB_DEPTH and no pop in the same cycle drops the write and sets `wb_overflow`.
  - A push and a pop in the same cycle at full is legal; count is unchanged.
- Head and tail wrap modulo WB_DEPTH.

## Timing
- Command, accepted and tag outputs are combinational from inputs and registered buffer state; there is no internal latency.
- A writeback pushed in cycle t is visible at the head at the earliest in t+1, so it can issue at the earliest in t+1.
- A dcache read in cycle t that matches a writeback arriving in the same cycle t is never issued in t.
- Reset values: buffer empty; head, tail and count 0; `wb_full` 0; `wb_overflow` 0.
- Reset discards buffer contents mid-operation. While `reset` is high, all combinational outputs are driven to idle.

## Configuration
- `MEM_ARB_RAW_CHECK_EN` defined:
  - Priority is dcache read, then icache read, then buffered store.
  - A dcache read is blocked when its tag matches any valid buffer entry or the same-cycle incoming writeback. In that cycle the store at the head takes its place.
  - When count == WB_DEPTH, the store at the head takes priority over all reads.
  - Icache reads are never address-checked.
- Undefined: the conservative store-first priority described in Operation; no comparators are instantiated.

## Structure
- Shared package:
  - MEM_COMMAND enum.
  - WB_ENTRY typedef: valid, tag, MEM_BLOCK data.
  - `MEM_ARB_WB_DEPTH` default constant.
- One sub-module, `wb_fifo`:
  - Push/pop FIFO with full, empty, count, head entry and a flat entry-array output for tag comparison.
  - The arbiter holds the priority logic, overflow flag and output muxing.

## Test plan
- Isolated reads:
  - icache read of 0x1000 with tag 3 returned → command LOAD, addr 0x1000, `icache_req_accepted` 1, `current_req_tag` 3.
  - Same read with tag 0 → accepted 0, retried the next cycle.
- Simultaneous requests:
  - Dcache read 0x2000 and icache read 0x3000 in the same cycle → dcache issues first; icache issues the cycle after.
- Writeback drain:
  - Writeback 0x4000 with data 0xDEADBEEF_CAFEF00D in cycle t → STORE at t+1 with that data; `current_req_tag` 0.
- Read after write (raw-check build):
  - Writeback 0x5000 at t, then dcache read 0x5000 at t+1 → STORE issues first; LOAD no earlier than the cycle after the pop.
  - Read of 0x6000 at t+1 → LOAD wins over the store.
- Overflow:
  - WB_DEPTH+1 writebacks on consecutive cycles with memory returning tag 0 → `wb_full` 1 after WB_DEPTH pushes; `wb_overflow` set; exactly WB_DEPTH stores later issue in FIFO order.
- Full push-and-pop plus reset:
  - At full, a writeback in the same cycle as an accepted store → count stays WB_DEPTH; no overflow.
  - Reset asserted with 2 entries pending → command MEM_NONE the next cycle; no stores are issued afterwards.
